sr_pulse_gen: RTL and testbench

SR_PULSE_GEN -- requirements
Module: sr_pulse_gen

---
 rtl/sr_pkg.sv | 26 ++
 rtl/pulse_timer.sv | 24 ++
 rtl/sr_pulse_gen.sv | 125 ++++++++++++
 tb/tb_sr_pulse_gen.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the SR latch pulse generator: FSM encoding,
// parameter limits and the timer load helper.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SET_PULSE = 2'd1,
    CLR_PULSE = 2'd2,
    GAP       = 2'd3
  } sr_state_t;

  localparam int unsigned PULSE_W_MIN = 1;
  localparam int unsigned PULSE_W_MAX = 15;
  localparam int unsigned GAP_W_MIN   = 0;
  localparam int unsigned GAP_W_MAX   = 15;

  // Timer load value for a phase lasting w cycles, w clamped to [lo, hi].
  function automatic logic [3:0] cnt_load(input int unsigned w,
                                          input int unsigned lo,
                                          input int unsigned hi);
    int unsigned c;
    c = (w < lo) ? lo : ((w > hi) ? hi : w);
    return (c == 0) ? 4'd0 : 4'(c - 1);
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// 4-bit loadable down-counter with zero flag; times pulse and gap phases.
module pulse_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && (count != '0))
      count <= count - 4'd1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sr_pulse_gen.sv
// Drives a downstream SR latch with fixed-width, mutually exclusive S/R pulses
// on handshaked requests, tracking the expected latch state and a pulse count.
module sr_pulse_gen
  import sr_pkg::*;
#(
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned GAP_W   = 1
) (
  input  logic       Ck,
  input  logic       Rst,
  input  logic       SetReq,
  input  logic       ClrReq,
  output logic       S,
  output logic       R,
  output logic       Ack,
  output logic       Done,
  output logic       Err,
  output logic       Busy,
  output logic       QExp,
  output logic [7:0] PulseCnt
);

  localparam logic [3:0] PULSE_LOAD = cnt_load(PULSE_W, PULSE_W_MIN, PULSE_W_MAX);
  localparam logic [3:0] GAP_LOAD   = cnt_load(GAP_W, GAP_W_MIN, GAP_W_MAX);
  localparam bit         HAS_GAP    = (GAP_W != 0);

  sr_state_t  state, state_n;
  logic       s_n, r_n, ack_n, done_n, err_n, qexp_n;
  logic [7:0] cnt_n;
  logic       t_load, t_dec, t_zero;
  logic [3:0] t_load_val;

  pulse_timer u_timer (
    .clk      (Ck),
    .rst      (Rst),
    .load     (t_load),
    .load_val (t_load_val),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  always_ff @(posedge Ck) begin
    if (Rst) begin
      state    <= IDLE;
      S        <= 1'b0;
      R        <= 1'b0;
      Ack      <= 1'b0;
      Done     <= 1'b0;
      Err      <= 1'b0;
      QExp     <= 1'b0;
      PulseCnt <= '0;
    end else begin
      state    <= state_n;
      S        <= s_n;
      R        <= r_n;
      Ack      <= ack_n;
      Done     <= done_n;
      Err      <= err_n;
      QExp     <= qexp_n;
      PulseCnt <= cnt_n;
    end
  end

  // S/R are only ever driven from distinct states, so they cannot overlap.
  always_comb begin
    state_n    = state;
    s_n        = 1'b0;
    r_n        = 1'b0;
    ack_n      = 1'b0;
    done_n     = 1'b0;
    err_n      = 1'b0;
    qexp_n     = QExp;
    cnt_n      = PulseCnt;
    t_load     = 1'b0;
    t_load_val = '0;
    t_dec      = 1'b0;
    unique case (state)
      IDLE: begin
        if (SetReq && !ClrReq) begin
          state_n    = SET_PULSE;
          s_n        = 1'b1;
          ack_n      = 1'b1;
          t_load     = 1'b1;
          t_load_val = PULSE_LOAD;
        end else if (ClrReq && !SetReq) begin
          state_n    = CLR_PULSE;
          r_n        = 1'b1;
          ack_n      = 1'b1;
          t_load     = 1'b1;
          t_load_val = PULSE_LOAD;
        end else if (SetReq && ClrReq) begin
          err_n = 1'b1;
        end
      end
      SET_PULSE, CLR_PULSE: begin
        if (!t_zero) begin
          t_dec = 1'b1;
          s_n   = (state == SET_PULSE);
          r_n   = (state == CLR_PULSE);
        end else begin
          done_n = 1'b1;
          qexp_n = (state == SET_PULSE);
          cnt_n  = PulseCnt + 8'd1;
          if (HAS_GAP) begin
            state_n    = GAP;
            t_load     = 1'b1;
            t_load_val = GAP_LOAD;
          end else begin
            state_n = IDLE;
          end
        end
      end
      GAP: begin
        if (t_zero)
          state_n = IDLE;
        else
          t_dec = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Directed self-checking bench for sr_pulse_gen (default and PULSE_W=1/GAP_W=0).
module tb_sr_pulse_gen;

  logic       Ck = 1'b0;
  logic       Rst, SetReq, ClrReq, SetReq2, ClrReq2;
  logic       S, R, Ack, Done, Err, Busy, QExp;
  logic       S2, R2, Ack2, Done2, Err2, Busy2, QExp2;
  logic [7:0] PulseCnt, PulseCnt2;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned failed = 0;
  logic [7:0]  model_cnt;
  logic        model_q;

  sr_pulse_gen #(.PULSE_W(2), .GAP_W(1)) dut (
    .Ck(Ck), .Rst(Rst), .SetReq(SetReq), .ClrReq(ClrReq),
    .S(S), .R(R), .Ack(Ack), .Done(Done), .Err(Err), .Busy(Busy),
    .QExp(QExp), .PulseCnt(PulseCnt)
  );

  sr_pulse_gen #(.PULSE_W(1), .GAP_W(0)) dut2 (
    .Ck(Ck), .Rst(Rst), .SetReq(SetReq2), .ClrReq(ClrReq2),
    .S(S2), .R(R2), .Ack(Ack2), .Done(Done2), .Err(Err2), .Busy(Busy2),
    .QExp(QExp2), .PulseCnt(PulseCnt2)
  );

  always #5 Ck = ~Ck;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Ck);
    #1;
  endtask

  always @(negedge Ck) begin
    if (Rst === 1'b0) begin
      check("no_overlap", 8'({S, R}) & 8'(S & R), 8'd0);
      check("no_overlap2", 8'(S2 & R2), 8'd0);
    end
  end

  // One full handshaked pulse on the default instance, with width/count/QExp checks.
  task automatic do_pulse(input bit is_set);
    bit          seen;
    int unsigned width;
    SetReq = is_set;
    ClrReq = !is_set;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (Ack) seen = 1'b1;
    end
    check("ack_seen", 8'(seen), 8'd1);
    SetReq = 1'b0;
    ClrReq = 1'b0;
    width = is_set ? int'(S) : int'(R);
    seen = 1'b0;
    for (int i = 0; i < 32 && !seen; i++) begin
      tick();
      if (Done) seen = 1'b1;
      else width += is_set ? int'(S) : int'(R);
    end
    check("done_seen", 8'(seen), 8'd1);
    model_cnt = model_cnt + 8'd1;
    model_q   = is_set;
    check("pulse_width", 8'(width), 8'd2);
    check("pulse_cnt", PulseCnt, model_cnt);
    check("qexp", 8'(QExp), 8'(model_q));
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      tick();
      if (!Busy) seen = 1'b1;
    end
    check("idle_seen", 8'(seen), 8'd1);
  endtask

  initial begin
    Rst = 1'b1; SetReq = 1'b0; ClrReq = 1'b0; SetReq2 = 1'b0; ClrReq2 = 1'b0;
    tick(); tick();
    check("rst_s", 8'(S), 8'd0);
    check("rst_busy", 8'(Busy), 8'd0);
    check("rst_cnt", PulseCnt, 8'd0);
    check("rst_outs", 8'({R, Ack, Done, Err, QExp}), 8'd0);
    Rst = 1'b0;
    tick();
    check("idle_busy", 8'(Busy), 8'd0);

    // Basic set pulse timing
    SetReq = 1'b1;
    tick();
    check("c1_ack", 8'(Ack), 8'd1);
    check("c1_s", 8'(S), 8'd1);
    check("c1_busy", 8'(Busy), 8'd1);
    SetReq = 1'b0;
    tick();
    check("c2_s", 8'(S), 8'd1);
    check("c2_ack", 8'(Ack), 8'd0);
    check("c2_done", 8'(Done), 8'd0);
    tick();
    check("c3_s", 8'(S), 8'd0);
    check("c3_done", 8'(Done), 8'd1);
    check("c3_qexp", 8'(QExp), 8'd1);
    check("c3_cnt", PulseCnt, 8'd1);
    check("c3_busy", 8'(Busy), 8'd1);
    tick();
    check("c4_busy", 8'(Busy), 8'd0);
    check("c4_done", 8'(Done), 8'd0);

    // Conflicting requests
    SetReq = 1'b1; ClrReq = 1'b1;
    tick();
    check("cf_err", 8'(Err), 8'd1);
    check("cf_ack", 8'(Ack), 8'd0);
    check("cf_sr", 8'({S, R}), 8'd0);
    check("cf_qexp", 8'(QExp), 8'd1);
    check("cf_busy", 8'(Busy), 8'd0);
    SetReq = 1'b0; ClrReq = 1'b0;
    tick();
    check("cf_err_once", 8'(Err), 8'd0);

    // Clear request held from cycle 1 of a set pulse
    SetReq = 1'b1;
    tick();
    check("h1_ack", 8'(Ack), 8'd1);
    SetReq = 1'b0; ClrReq = 1'b1;
    tick();
    check("h2_ack", 8'(Ack), 8'd0);
    check("h2_sr", 8'({S, R}), 8'b10);
    tick();
    check("h3_ack_err", 8'({Ack, Err}), 8'd0);
    check("h3_done", 8'(Done), 8'd1);
    tick();
    check("h4_ack", 8'(Ack), 8'd0);
    check("h4_busy", 8'(Busy), 8'd0);
    tick();
    check("h5_ack", 8'(Ack), 8'd1);
    check("h5_sr", 8'({S, R}), 8'b01);
    ClrReq = 1'b0;
    tick();
    check("h6_r", 8'(R), 8'd1);
    tick();
    check("h7_r", 8'(R), 8'd0);
    check("h7_done", 8'(Done), 8'd1);
    check("h7_qexp", 8'(QExp), 8'd0);
    check("h7_cnt", PulseCnt, 8'd3);
    tick();

    // Redundant set pulses
    model_cnt = 8'd3;
    model_q   = 1'b0;
    do_pulse(1'b1);
    do_pulse(1'b1);

    // Reset in cycle 2 of a set pulse, with a request on the reset edge
    SetReq = 1'b1;
    tick();
    check("r1_ack", 8'(Ack), 8'd1);
    SetReq = 1'b0;
    tick();
    check("r2_s", 8'(S), 8'd1);
    Rst = 1'b1; SetReq = 1'b1;
    tick();
    check("r3_s", 8'(S), 8'd0);
    check("r3_busy", 8'(Busy), 8'd0);
    check("r3_qexp", 8'(QExp), 8'd0);
    check("r3_cnt", PulseCnt, 8'd0);
    check("r3_done_ack", 8'({Done, Ack}), 8'd0);
    Rst = 1'b0; SetReq = 1'b0;
    tick();
    check("r4_done", 8'(Done), 8'd0);
    check("r4_busy", 8'(Busy), 8'd0);

    // 256 alternating pulses, last one a set; counter wraps to zero
    model_cnt = 8'd0;
    model_q   = 1'b0;
    for (int i = 0; i < 256; i++) do_pulse(i % 2 == 1);
    check("wrap_cnt", PulseCnt, 8'd0);
    check("wrap_qexp", 8'(QExp), 8'd1);

    // PULSE_W=1, GAP_W=0 instance
    SetReq2 = 1'b1;
    tick();
    check("n1_ack_s", 8'({Ack2, S2}), 8'b11);
    SetReq2 = 1'b0; ClrReq2 = 1'b1;
    tick();
    check("n2_s", 8'(S2), 8'd0);
    check("n2_done", 8'(Done2), 8'd1);
    check("n2_busy", 8'(Busy2), 8'd0);
    check("n2_qexp", 8'(QExp2), 8'd1);
    tick();
    check("n3_ack_r", 8'({Ack2, R2}), 8'b11);
    ClrReq2 = 1'b0;
    tick();
    check("n4_r", 8'(R2), 8'd0);
    check("n4_done", 8'(Done2), 8'd1);
    check("n4_qexp", 8'(QExp2), 8'd0);
    check("n4_cnt", PulseCnt2, 8'd2);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
